// File: rtl/proc_pkg.sv
// ============================================================================
// proc_pkg : shared widths, FSM state type and flag bit positions
// Rev 1.0
// ============================================================================
`default_nettype none

package proc_pkg;

    localparam int DATA_W    = 16;
    localparam int OPC_W     = 4;
    localparam int REG_IDX_W = 3;
    localparam int NUM_REGS  = 8;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/issue_regfile.sv
// ============================================================================
// issue_regfile : 8x16 register file, 2 read ports, writeback + host load
// (writeback beats load on the same index), combinational debug read. Rev 1.0
// ============================================================================
`default_nettype none

module issue_regfile
    import proc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1_addr_i,
    input  logic [REG_IDX_W-1:0] rs2_addr_i,
    output logic [DATA_W-1:0]    rs1_data_o,
    output logic [DATA_W-1:0]    rs2_data_o,
    input  logic                 wb_en_i,
    input  logic [REG_IDX_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0]    wb_data_i,
    input  logic                 ld_en_i,
    input  logic [REG_IDX_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0]    ld_data_i,
    input  logic [REG_IDX_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0]    dbg_data_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // The writeback assignment comes last so it overrides a same-index load.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (ld_en_i) begin
                regs_q[ld_addr_i] <= ld_data_i;
            end
            if (wb_en_i) begin
                regs_q[wb_addr_i] <= wb_data_i;
            end
        end
    end

    assign rs1_data_o = regs_q[rs1_addr_i];
    assign rs2_data_o = regs_q[rs2_addr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// alu_issue_ctrl : IDLE->READ->EXEC->WB issue controller for an external ALU.
// Optional immediate operand when ALU_ISSUE_IMM_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module alu_issue_ctrl
    import proc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPC_W-1:0]     in_opcode,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic                 in_wb,
`ifdef ALU_ISSUE_IMM_EN
    input  logic                 in_imm_sel,
    input  logic [DATA_W-1:0]    in_imm,
`endif
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [OPC_W-1:0]     alu_opcode,
    input  logic [DATA_W-1:0]    alu_out,
    input  logic                 alu_zero,
    input  logic                 alu_neg,
    input  logic                 alu_ovf,
    input  logic                 ld_en,
    input  logic [REG_IDX_W-1:0] ld_addr,
    input  logic [DATA_W-1:0]    ld_data,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]    dbg_data,
    output logic                 done,
    output logic [DATA_W-1:0]    result,
    output logic [2:0]           flags
);

    state_e state_q, state_d;

    logic [OPC_W-1:0]     opc_q;
    logic [REG_IDX_W-1:0] rd_q, rs1_q, rs2_q;
    logic                 wb_q;
    logic [DATA_W-1:0]    alu_a_q, alu_b_q;
    logic [OPC_W-1:0]     alu_opc_q;
    logic [DATA_W-1:0]    result_q;
    logic [2:0]           flag_cap_q, flags_q;
    logic [DATA_W-1:0]    rs1_data, rs2_data, op_b_src;
    logic                 accept;
    logic [2:0]           alu_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) state_d = READ;
            end
            READ: state_d = EXEC;
            EXEC: state_d = WB;
            WB: begin
                done    = !rst;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = (state_q == IDLE) && in_valid;

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_Z] = alu_zero;
        alu_flags[FLAG_N] = alu_neg;
        alu_flags[FLAG_V] = alu_ovf;
    end

`ifdef ALU_ISSUE_IMM_EN
    logic              imm_sel_q;
    logic [DATA_W-1:0] imm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
        end else if (accept) begin
            imm_sel_q <= in_imm_sel;
            imm_q     <= in_imm;
        end
    end

    assign op_b_src = imm_sel_q ? imm_q : rs2_data;
`else
    assign op_b_src = rs2_data;
`endif

    // Operand registers double as the ALU drivers, so they only move on READ->EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            opc_q      <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            wb_q       <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_opc_q  <= '0;
            result_q   <= '0;
            flag_cap_q <= '0;
            flags_q    <= '0;
        end else begin
            if (accept) begin
                opc_q <= in_opcode;
                rd_q  <= in_rd;
                rs1_q <= in_rs1;
                rs2_q <= in_rs2;
                wb_q  <= in_wb;
            end
            if (state_q == READ) begin
                alu_a_q   <= rs1_data;
                alu_b_q   <= op_b_src;
                alu_opc_q <= opc_q;
            end
            if (state_q == EXEC) begin
                result_q   <= alu_out;
                flag_cap_q <= alu_flags;
            end
            if (state_q == WB) begin
                flags_q <= flag_cap_q;
            end
        end
    end

    issue_regfile u_regfile (
        .clk        (clk),
        .rst        (rst),
        .rs1_addr_i (rs1_q),
        .rs2_addr_i (rs2_q),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data),
        .wb_en_i    ((state_q == WB) && wb_q),
        .wb_addr_i  (rd_q),
        .wb_data_i  (result_q),
        .ld_en_i    (ld_en),
        .ld_addr_i  (ld_addr),
        .ld_data_i  (ld_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opc_q;
    assign result     = result_q;
    assign flags      = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// tb_alu_issue_ctrl : directed bench with ALU stub and cycle-level reference
// model of the issue controller. Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_opcode = '0;
    logic [2:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic        in_wb = 1'b0;
    logic        in_imm_sel = 1'b0;
    logic [15:0] in_imm = '0;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_opcode;
    logic        alu_zero, alu_neg, alu_ovf;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;
    logic        done;
    logic [15:0] result;
    logic [2:0]  flags;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_wb      (in_wb),
`ifdef ALU_ISSUE_IMM_EN
        .in_imm_sel (in_imm_sel),
        .in_imm     (in_imm),
`endif
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .alu_ovf    (alu_ovf),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .done       (done),
        .result     (result),
        .flags      (flags)
    );

    // ALU stub: returns {ovf, neg, zero, result}
    function automatic logic [18:0] stub(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] op);
        logic [15:0] r;
        case (op)
            4'd15:   r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a ^ b;
            4'd3:    r = b;
            default: r = a & b;
        endcase
        return {a[15] & b[15], r[15], (r == 16'h0), r};
    endfunction

    logic [18:0] stub_v;
    always_comb begin
        stub_v   = stub(alu_a, alu_b, alu_opcode);
        alu_out  = stub_v[15:0];
        alu_zero = stub_v[16];
        alu_neg  = stub_v[17];
        alu_ovf  = stub_v[18];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_age counts cycles since the accepting edge (0 = idle)
    logic [15:0] m_rf [8];
    logic [15:0] old_rf [8];
    logic [15:0] m_a = '0, m_b = '0, m_res = '0;
    logic [3:0]  m_opc = '0;
    logic [2:0]  m_flags = '0, m_cap = '0;
    int          m_age = 0;
    int          m_accepts = 0;
    logic [3:0]  p_opc;
    logic [2:0]  p_rd, p_rs1, p_rs2;
    logic        p_wb, p_isel, wb_now;
    logic [15:0] p_imm;
    logic [18:0] m_s;

    always @(posedge clk) begin
        old_rf = m_rf;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_rf[i] = '0;
            m_a = '0; m_b = '0; m_opc = '0; m_res = '0;
            m_flags = '0; m_cap = '0; m_age = 0;
        end else begin
            wb_now = (m_age == 3) && p_wb;
            case (m_age)
                0: if (in_valid) begin
                    p_opc = in_opcode; p_rd = in_rd; p_rs1 = in_rs1; p_rs2 = in_rs2;
                    p_wb = in_wb; p_imm = in_imm;
`ifdef ALU_ISSUE_IMM_EN
                    p_isel = in_imm_sel;
`else
                    p_isel = 1'b0;
`endif
                    m_age = 1;
                    m_accepts++;
                end
                1: begin
                    m_a   = old_rf[p_rs1];
                    m_b   = p_isel ? p_imm : old_rf[p_rs2];
                    m_opc = p_opc;
                    m_age = 2;
                end
                2: begin
                    m_s   = stub(m_a, m_b, m_opc);
                    m_res = m_s[15:0];
                    m_cap = m_s[18:16];
                    m_age = 3;
                end
                default: begin
                    m_flags = m_cap;
                    m_age   = 0;
                end
            endcase
            if (ld_en) m_rf[ld_addr] = ld_data;
            if (wb_now) m_rf[p_rd] = m_res;
        end
    end

    always @(posedge clk) begin
        #1;
        check("in_ready",   {31'b0, in_ready}, {31'b0, (m_age == 0) && !rst});
        check("done",       {31'b0, done},     {31'b0, (m_age == 3) && !rst});
        check("alu_a",      {16'b0, alu_a},    {16'b0, m_a});
        check("alu_b",      {16'b0, alu_b},    {16'b0, m_b});
        check("alu_opcode", {28'b0, alu_opcode}, {28'b0, m_opc});
        check("result",     {16'b0, result},   {16'b0, m_res});
        check("flags",      {29'b0, flags},    {29'b0, m_flags});
        check("dbg_data",   {16'b0, dbg_data}, {16'b0, m_rf[dbg_addr]});
        if (done) done_cnt++;
    end

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Returns at the negedge inside the READ cycle
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic wb, input logic isel,
                         input logic [15:0] imm);
        @(negedge clk);
        in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_wb = wb; in_imm_sel = isel; in_imm = imm;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dbg_addr = dbg_addr + 3'd1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    int acc0, done0;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_in_ready", {31'b0, in_ready}, 32'd0);
        check("reset_result",   {16'b0, result},   32'd0);
        rst = 1'b0;
        idle(2);

        // Basic issue: 7 + 5 -> r3
        load(3'd1, 16'd7);
        load(3'd2, 16'd5);
        issue(4'd15, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0, 16'h0);
        @(negedge clk);
        check("basic_alu_a",   {16'b0, alu_a},        32'd7);
        check("basic_alu_b",   {16'b0, alu_b},        32'd5);
        check("basic_opcode",  {28'b0, alu_opcode},   32'd15);
        dbg_addr = 3'd3;
        @(negedge clk);
        check("basic_done",    {31'b0, done},         32'd1);
        @(negedge clk);
        check("basic_rf3",     {16'b0, dbg_data},     32'h000C);
        check("basic_flags",   {29'b0, flags},        32'd0);
        check("model_rf3",     {16'b0, m_rf[3]},      32'h000C);

        // Flags-only: 12 - 12 = 0, no writeback
        issue(4'd1, 3'd3, 3'd3, 3'd3, 1'b0, 1'b0, 16'h0);
        repeat (3) @(negedge clk);
        check("flagsonly_flags", {29'b0, flags},      32'b001);
        check("flagsonly_rf3",   {16'b0, dbg_data},   32'h000C);

        // Load collision: WB of 0x1234 to r3 vs host load of 0xAAAA
        load(3'd4, 16'h1234);
        issue(4'd15, 3'd3, 3'd4, 3'd5, 1'b1, 1'b0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 3'd3; ld_data = 16'hAAAA;
        @(negedge clk);
        ld_en = 1'b0;
        check("collision_rf3", {16'b0, dbg_data},     32'h1234);

        // Load to rs1 during READ is not seen by the read
        issue(4'd2, 3'd6, 3'd1, 3'd2, 1'b1, 1'b0, 16'h0);
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'hFFFF;
        @(negedge clk);
        ld_en = 1'b0;
        check("readload_alu_a", {16'b0, alu_a},       32'd7);
        dbg_addr = 3'd6;
        repeat (2) @(negedge clk);
        check("readload_rf6",   {16'b0, dbg_data},    32'd2);

        // Backpressure: in_valid held for 6 edges -> exactly two accepts
        acc0 = m_accepts; done0 = done_cnt;
        @(negedge clk);
        in_valid = 1'b1; in_opcode = 4'd3; in_rd = 3'd7; in_rs1 = 3'd0; in_rs2 = 3'd2;
        in_wb = 1'b1; in_imm_sel = 1'b0;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        dbg_addr = 3'd7;
        repeat (4) @(negedge clk);
        check("bp_model_accepts", m_accepts - acc0,   32'd2);
        check("bp_done_count",    done_cnt - done0,   32'd2);
        check("bp_rf7",           {16'b0, dbg_data},  32'd5);

        // Reset during EXEC abandons the instruction
        done0 = done_cnt;
        dbg_addr = 3'd4;
        issue(4'd15, 3'd4, 3'd1, 3'd2, 1'b1, 1'b0, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready},      32'd1);
        check("rst_no_done",  done_cnt - done0,       32'd0);
        check("rst_flags",    {29'b0, flags},         32'd0);
        check("rst_rf4",      {16'b0, dbg_data},      32'd0);
        idle(3);

`ifdef ALU_ISSUE_IMM_EN
        load(3'd2, 16'h7777);
        issue(4'd15, 3'd5, 3'd2, 3'd2, 1'b1, 1'b1, 16'h0100);
        @(negedge clk);
        check("imm_alu_b", {16'b0, alu_b},            32'h0100);
        idle(3);
`endif

        // Extra pattern: AND with a negative operand sets neg and ovf via the stub
        load(3'd1, 16'hF0F0);
        load(3'd2, 16'h8F00);
        issue(4'd4, 3'd0, 3'd1, 3'd2, 1'b1, 1'b0, 16'h0);
        dbg_addr = 3'd0;
        repeat (3) @(negedge clk);
        check("and_rf0",   {16'b0, dbg_data},         32'h8000);
        check("and_flags", {29'b0, flags},            32'b110);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
